// File: rtl/window_dispatcher_pkg.sv
// Shared types and sizing for the window dispatcher.
// globalDefinitions carries the system-wide core count.
package globalDefinitions;
   localparam int cores = 4;
endpackage

package pkg_windowDispatcher;
   import globalDefinitions::*;

   localparam int CORES  = cores;
   localparam int CORE_W = $clog2(CORES);

   typedef enum logic [1:0] {
      S_Idle,
      S_Dispatch,
      S_Drain,
      S_Done
   } DISP_STATES_t;
endpackage

// File: rtl/window_dispatcher_if.sv
// Window and result streams of the dispatcher.
// master = controller side, slave = dispatcher side.
interface window_dispatcher_if #(
   parameter int COORD_W = 16,
   parameter int CORE_W  = pkg_windowDispatcher::CORE_W
);
   logic               win_valid;
   logic               win_ready;
   logic [COORD_W-1:0] win_x;
   logic [COORD_W-1:0] win_y;
   logic               win_last;
   logic               res_valid;
   logic               res_ready;
   logic [COORD_W-1:0] res_x;
   logic [COORD_W-1:0] res_y;
   logic               res_pass;
   logic [CORE_W-1:0]  res_core;

   modport master (
      output win_valid, win_x, win_y, win_last, res_ready,
      input  win_ready, res_valid, res_x, res_y, res_pass, res_core
   );

   modport slave (
      input  win_valid, win_x, win_y, win_last, res_ready,
      output win_ready, res_valid, res_x, res_y, res_pass, res_core
   );
endinterface

// File: rtl/window_dispatcher_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), idx, any out.
module rr_pick #(
   parameter int W  = 4,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [W-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);
   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < W; k++) begin
         j = (int'(ptr) + k) % W;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = PW'(j);
         end
      end
   end
endmodule

// File: rtl/window_dispatcher.sv
// Dispatches scale-pass windows to classifier cores round-robin and
// merges verdicts into one ordered result stream.
// Ports: clk, reset (async, high), scale_start, bus (window/result
// streams), core_start/x/y, core_done/pass, scale_done, outstanding.
// Optional: WINDOW_DISPATCH_STATS_EN adds stat_windows/stat_passes.
module window_dispatcher #(
   parameter int CORES   = pkg_windowDispatcher::CORES,
   parameter int COORD_W = 16,
   parameter int CORE_W  = $clog2(CORES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               scale_start,
   window_dispatcher_if.slave bus,
   output logic [CORES-1:0]   core_start,
   output logic [COORD_W-1:0] core_x,
   output logic [COORD_W-1:0] core_y,
   input  logic [CORES-1:0]   core_done,
   input  logic [CORES-1:0]   core_pass,
   output logic               scale_done,
   output logic [CORE_W:0]    outstanding
`ifdef WINDOW_DISPATCH_STATS_EN
   ,
   output logic [31:0]        stat_windows,
   output logic [31:0]        stat_passes
`endif
);
   import pkg_windowDispatcher::*;

   DISP_STATES_t state, state_nx;

   logic [CORES-1:0]   inflight, pending, pass_q;
   logic [CORES-1:0]   done_q, dpass_q, done_hit, avail;
   logic [COORD_W-1:0] xs [CORES];
   logic [COORD_W-1:0] ys [CORES];
   logic [CORE_W-1:0]  disp_ptr, res_ptr;
   logic [CORES-1:0]   d_gnt, r_gnt, launch_g;
   logic [CORE_W-1:0]  d_idx, r_idx;
   logic               d_any, r_any;
   logic [COORD_W-1:0] launch_x, launch_y;
   logic               accept, res_take, res_load, start_ok;

   function automatic logic [CORE_W-1:0] inc_wrap(
      input logic [CORE_W-1:0] i
   );
      return (int'(i) == CORES - 1) ? '0 : i + 1'b1;
   endfunction

   assign avail    = ~inflight & ~pending;
   assign done_hit = done_q & inflight;
   assign start_ok = (state == S_Idle) && scale_start;
   assign accept   = bus.win_valid && bus.win_ready;
   assign res_take = bus.res_valid && bus.res_ready;
   assign res_load = !bus.res_valid || bus.res_ready;

   assign bus.win_ready = (state == S_Dispatch) && d_any;

   rr_pick #(.W(CORES), .PW(CORE_W)) u_disp_pick (
      .req(avail), .ptr(disp_ptr),
      .gnt(d_gnt), .idx(d_idx), .any(d_any)
   );

   rr_pick #(.W(CORES), .PW(CORE_W)) u_res_pick (
      .req(pending), .ptr(res_ptr),
      .gnt(r_gnt), .idx(r_idx), .any(r_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_Idle;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      scale_done = 1'b0;
      unique case (state)
         S_Idle:
            if (scale_start) state_nx = S_Dispatch;
         S_Dispatch:
            if (accept && bus.win_last) state_nx = S_Drain;
         S_Drain:
            if (inflight == '0 && pending == '0 && !bus.res_valid)
               state_nx = S_Done;
         S_Done: begin
            scale_done = 1'b1;
            state_nx   = S_Idle;
         end
         default: state_nx = S_Idle;
      endcase
   end

   // Done/pass are registered once before capture, and the start pulse
   // goes out one cycle after acceptance from the launch register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight     <= '0;
         pending      <= '0;
         pass_q       <= '0;
         done_q       <= '0;
         dpass_q      <= '0;
         disp_ptr     <= '0;
         res_ptr      <= '0;
         launch_g     <= '0;
         launch_x     <= '0;
         launch_y     <= '0;
         core_start   <= '0;
         core_x       <= '0;
         core_y       <= '0;
         bus.res_valid <= 1'b0;
         bus.res_x    <= '0;
         bus.res_y    <= '0;
         bus.res_pass <= 1'b0;
         bus.res_core <= '0;
         outstanding  <= '0;
         for (int i = 0; i < CORES; i++) begin
            xs[i] <= '0;
            ys[i] <= '0;
         end
      end else begin
         done_q   <= core_done;
         dpass_q  <= core_pass;
         launch_g <= accept ? d_gnt : '0;
         if (accept) begin
            launch_x <= bus.win_x;
            launch_y <= bus.win_y;
         end
         core_start <= launch_g;
         core_x     <= launch_x;
         core_y     <= launch_y;

         for (int i = 0; i < CORES; i++) begin
            if (accept && d_gnt[i]) begin
               xs[i] <= bus.win_x;
               ys[i] <= bus.win_y;
            end
            if (done_hit[i]) pass_q[i] <= dpass_q[i];
         end

         inflight <= (inflight & ~done_hit) | (accept ? d_gnt : '0);
         pending  <= (pending | done_hit) & ~(res_load ? r_gnt : '0);

         if (res_load) begin
            bus.res_valid <= r_any;
            if (r_any) begin
               bus.res_x    <= xs[r_idx];
               bus.res_y    <= ys[r_idx];
               bus.res_pass <= pass_q[r_idx];
               bus.res_core <= r_idx;
               res_ptr      <= inc_wrap(r_idx);
            end
         end

         if (accept) disp_ptr <= inc_wrap(d_idx);
         if (start_ok) begin
            disp_ptr <= '0;
            res_ptr  <= '0;
         end

         if (accept && !res_take)
            outstanding <= outstanding + 1'b1;
         else if (!accept && res_take)
            outstanding <= outstanding - 1'b1;
      end
   end

`ifdef WINDOW_DISPATCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_windows <= '0;
         stat_passes  <= '0;
      end else if (start_ok) begin
         stat_windows <= '0;
         stat_passes  <= '0;
      end else begin
         if (accept && !(&stat_windows))
            stat_windows <= stat_windows + 1'b1;
         if (res_take && bus.res_pass && !(&stat_passes))
            stat_passes <= stat_passes + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_window_dispatcher.sv
// Self-checking bench for window_dispatcher (4 cores):
// directed scenarios plus randomized passes against a scoreboard.
module tb_window_dispatcher;
   localparam int NC = 4;
   localparam int CW = 16;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          scale_start;
   logic [NC-1:0] core_start, core_done, core_pass;
   logic [CW-1:0] core_x, core_y;
   logic          scale_done;
   logic [IW:0]   outstanding;
`ifdef WINDOW_DISPATCH_STATS_EN
   logic [31:0]   stat_windows, stat_passes;
`endif

   int checks = 0;
   int errors = 0;

   logic [2*CW:0]   dq [NC][$];
   logic [2*CW-1:0] wq [$];

   always #5 clk = ~clk;

   window_dispatcher_if #(.COORD_W(CW), .CORE_W(IW)) bus ();

   window_dispatcher #(.CORES(NC), .COORD_W(CW), .CORE_W(IW)) dut (
      .clk(clk),
      .reset(reset),
      .scale_start(scale_start),
      .bus(bus),
      .core_start(core_start),
      .core_x(core_x),
      .core_y(core_y),
      .core_done(core_done),
      .core_pass(core_pass),
      .scale_done(scale_done),
      .outstanding(outstanding)
`ifdef WINDOW_DISPATCH_STATS_EN
      ,
      .stat_windows(stat_windows),
      .stat_passes(stat_passes)
`endif
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      scale_start   = 1'b0;
      bus.win_valid = 1'b0;
      bus.win_x     = '0;
      bus.win_y     = '0;
      bus.win_last  = 1'b0;
      bus.res_ready = 1'b0;
      core_done     = '0;
      core_pass     = '0;
   endtask

   task automatic open_scale();
      scale_start = 1'b1;
      tick();
      scale_start = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      #1;
      checks++;
      if (core_start !== '0 || core_x !== '0 || core_y !== '0) begin
         errors++;
         $display("FAIL reset_core: start=%b x=%0h y=%0h expected 0", core_start, core_x, core_y);
      end
      checks++;
      if (bus.win_ready !== 1'b0 || bus.res_valid !== 1'b0 || scale_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: win_ready=%b res_valid=%b scale_done=%b expected 0",
                  bus.win_ready, bus.res_valid, scale_done);
      end
      checks++;
      if (outstanding !== '0) begin
         errors++;
         $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
      end
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [NC-1:0] exp_s;
      bus.res_ready = 1'b1;
      open_scale();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            checks++;
            if (bus.win_ready !== 1'b1) begin
               errors++;
               $display("FAIL rr_ready[%0d]: got %b expected 1", k, bus.win_ready);
            end
            bus.win_valid = 1'b1;
            bus.win_x     = CW'(8 * k);
            bus.win_y     = '0;
         end else begin
            bus.win_valid = 1'b0;
         end
         if (k == 4) begin
            checks++;
            if (bus.win_ready !== 1'b0) begin
               errors++;
               $display("FAIL rr_full: win_ready got %b expected 0", bus.win_ready);
            end
         end
         exp_s = '0;
         if (k >= 2) exp_s[k-2] = 1'b1;
         checks++;
         if (core_start !== exp_s || (k >= 2 && core_x !== CW'(8 * (k - 2)))) begin
            errors++;
            $display("FAIL rr_start[%0d]: start=%b x=%0d expected start=%b x=%0d",
                     k, core_start, core_x, exp_s, 8 * (k - 2));
         end
         tick();
      end
   endtask

   task automatic test_simultaneous_done();
      logic [NC-1:0] dv   [2] = '{4'b1010, 4'b0101};
      logic [NC-1:0] pv   [2] = '{4'b1000, 4'b0001};
      int            c0   [2] = '{1, 0};
      int            c1   [2] = '{3, 2};
      int            oaft [2] = '{2, 0};
      int            c;
      for (int r = 0; r < 2; r++) begin
         core_done = dv[r];
         core_pass = pv[r];
         tick();
         core_done = '0;
         core_pass = '0;
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (k == 2 || k == 3) begin
               c = (k == 2) ? c0[r] : c1[r];
               if (bus.res_valid !== 1'b1 || bus.res_core !== IW'(c) ||
                   bus.res_pass !== pv[r][c] || bus.res_x !== CW'(8 * c)) begin
                  errors++;
                  $display("FAIL simul[%0d.%0d]: v=%b core=%0d pass=%b x=%0d expected v=1 core=%0d pass=%b x=%0d",
                           r, k, bus.res_valid, bus.res_core, bus.res_pass, bus.res_x,
                           c, pv[r][c], 8 * c);
               end
            end else if (k == 4) begin
               if (bus.res_valid !== 1'b0 || outstanding !== 3'(oaft[r])) begin
                  errors++;
                  $display("FAIL simul_end[%0d]: v=%b outstanding=%0d expected v=0 outstanding=%0d",
                           r, bus.res_valid, outstanding, oaft[r]);
               end
            end else begin
               if (bus.res_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL simul_lat[%0d.%0d]: res_valid=%b expected 0", r, k, bus.res_valid);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_backpressure();
      int order [4] = '{3, 0, 1, 2};
      logic [NC-1:0] pv = 4'b0110;
      int c;
      bus.res_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.win_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b expected 1", k, bus.win_ready);
         end
         bus.win_valid = 1'b1;
         bus.win_x     = CW'(100 + k);
         bus.win_y     = CW'(k);
         tick();
      end
      bus.win_valid = 1'b0;
      checks++;
      if (bus.win_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: win_ready got %b expected 0", bus.win_ready);
      end
      core_done = 4'b1111;
      core_pass = pv;
      tick();
      core_done = '0;
      core_pass = '0;
      repeat (5) tick();
      checks++;
      if (outstanding !== 3'd4 || bus.res_valid !== 1'b1 || bus.res_core !== IW'(3)) begin
         errors++;
         $display("FAIL bp_hold: outstanding=%0d v=%b core=%0d expected 4 1 3",
                  outstanding, bus.res_valid, bus.res_core);
      end
      bus.res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         c = order[k];
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_core !== IW'(c) ||
             bus.res_pass !== pv[c] || bus.res_x !== CW'(100 + c)) begin
            errors++;
            $display("FAIL bp_drain[%0d]: v=%b core=%0d pass=%b x=%0d expected core=%0d pass=%b x=%0d",
                     k, bus.res_valid, bus.res_core, bus.res_pass, bus.res_x, c, pv[c], 100 + c);
         end
         tick();
      end
      checks++;
      if (bus.res_valid !== 1'b0 || outstanding !== '0 || bus.win_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_after: v=%b outstanding=%0d win_ready=%b expected 0 0 1",
                  bus.res_valid, outstanding, bus.win_ready);
      end
   endtask

   task automatic test_spurious_done();
      bit saw = 0;
      int sd = 0;
      bus.res_ready = 1'b1;
      bus.win_valid = 1'b1;
      bus.win_x     = 16'd55;
      bus.win_y     = 16'd7;
      bus.win_last  = 1'b1;
      tick();
      bus.win_valid = 1'b0;
      bus.win_last  = 1'b0;
      tick();
      checks++;
      if (core_start !== 4'b0001) begin
         errors++;
         $display("FAIL spur_dispatch: core_start=%b expected 0001", core_start);
      end
      core_done = 4'b0100;
      tick();
      core_done = '0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.res_valid !== 1'b0 || outstanding !== 3'd1) begin
            errors++;
            $display("FAIL spur_ignore[%0d]: v=%b outstanding=%0d expected 0 1",
                     k, bus.res_valid, outstanding);
         end
         tick();
      end
      core_done = 4'b0001;
      core_pass = 4'b0001;
      tick();
      core_done = '0;
      core_pass = '0;
      for (int k = 0; k < 12; k++) begin
         if (bus.res_valid === 1'b1) begin
            saw = 1;
            checks++;
            if (bus.res_core !== '0 || bus.res_x !== 16'd55 || bus.res_y !== 16'd7 || bus.res_pass !== 1'b1) begin
               errors++;
               $display("FAIL spur_result: core=%0d x=%0d y=%0d pass=%b expected 0 55 7 1",
                        bus.res_core, bus.res_x, bus.res_y, bus.res_pass);
            end
         end
         if (scale_done === 1'b1) begin
            sd++;
            checks++;
            if (outstanding !== '0 || !saw) begin
               errors++;
               $display("FAIL spur_scale_done: outstanding=%0d result_seen=%0d expected 0 1", outstanding, saw);
            end
         end
         tick();
      end
      checks++;
      if (sd != 1 || !saw) begin
         errors++;
         $display("FAIL spur_end: scale_done pulses=%0d result_seen=%0d expected 1 1", sd, saw);
      end
   endtask

   task automatic test_random_pass(input int n);
      int sent = 0, got = 0, sd = 0, quiet = 0, npass = 0, g, cyc;
      int rem [NC];
      bit busy [NC];
      logic [CW-1:0] jx [NC], jy [NC];
      logic [2*CW:0] e;
      logic [2*CW-1:0] w;
      logic p;
      for (int i = 0; i < NC; i++) begin
         busy[i] = 0;
         rem[i]  = 0;
         jx[i]   = '0;
         jy[i]   = '0;
         dq[i].delete();
      end
      wq.delete();
      open_scale();
      for (cyc = 0; cyc < 3000 && quiet < 4; cyc++) begin
         if (core_start !== '0) begin
            checks++;
            g = 0;
            for (int i = 0; i < NC; i++) if (core_start[i] === 1'b1) g = i;
            if ($countones(core_start) != 1 || wq.size() == 0 || busy[g]) begin
               errors++;
               $display("FAIL rnd_dispatch: core_start=%b queued=%0d busy=%0d", core_start, wq.size(), busy[g]);
            end else begin
               w = wq.pop_front();
               if ({core_x, core_y} !== w) begin
                  errors++;
                  $display("FAIL rnd_coords: got %0h,%0h expected %0h,%0h",
                           core_x, core_y, w[2*CW-1:CW], w[CW-1:0]);
               end
               busy[g] = 1;
               rem[g]  = int'($urandom_range(1, 6));
               jx[g]   = core_x;
               jy[g]   = core_y;
            end
         end
         core_done = '0;
         core_pass = '0;
         for (int i = 0; i < NC; i++) begin
            if (busy[i]) begin
               rem[i]--;
               if (rem[i] == 0) begin
                  busy[i]      = 0;
                  p            = 1'($urandom % 2);
                  core_done[i] = 1'b1;
                  core_pass[i] = p;
                  dq[i].push_back({jx[i], jy[i], p});
               end
            end
         end
         bus.res_ready = ($urandom % 4) != 0;
         if (bus.res_valid === 1'b1 && bus.res_ready) begin
            checks++;
            got++;
            if (dq[bus.res_core].size() == 0) begin
               errors++;
               $display("FAIL rnd_result: core %0d reported with nothing completed", bus.res_core);
            end else begin
               e = dq[bus.res_core].pop_front();
               if (e[0]) npass++;
               if ({bus.res_x, bus.res_y, bus.res_pass} !== e) begin
                  errors++;
                  $display("FAIL rnd_payload: core=%0d got %0h expected %0h",
                           bus.res_core, {bus.res_x, bus.res_y, bus.res_pass}, e);
               end
            end
         end
         if (scale_done === 1'b1) begin
            sd++;
            checks++;
            if (got != n || outstanding !== '0 || sd != 1) begin
               errors++;
               $display("FAIL rnd_scale_done: results=%0d outstanding=%0d pulse=%0d expected %0d 0 1",
                        got, outstanding, sd, n);
            end
         end
         if (sd > 0) quiet++;
         bus.win_valid = (sent < n) && (($urandom % 3) != 0);
         bus.win_x     = 16'($urandom);
         bus.win_y     = 16'($urandom);
         bus.win_last  = (sent == n - 1);
         if (bus.win_valid && bus.win_ready === 1'b1) begin
            wq.push_back({bus.win_x, bus.win_y});
            sent++;
         end
         tick();
      end
      clear_inputs();
      checks++;
      if (sd != 1 || got != n || sent != n) begin
         errors++;
         $display("FAIL rnd_end[%0d]: pulses=%0d results=%0d sent=%0d cycles=%0d", n, sd, got, sent, cyc);
      end
`ifdef WINDOW_DISPATCH_STATS_EN
      checks++;
      if (stat_windows !== 32'(n) || stat_passes !== 32'(npass)) begin
         errors++;
         $display("FAIL rnd_stats: windows=%0d passes=%0d expected %0d %0d", stat_windows, stat_passes, n, npass);
      end
`endif
   endtask

   task automatic test_reset_mid_pass();
      open_scale();
      bus.res_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.win_valid = 1'b1;
         bus.win_x     = CW'(20 + k);
         bus.win_y     = CW'(k);
         tick();
      end
      bus.win_valid = 1'b0;
      checks++;
      if (outstanding !== 3'd3 || core_start !== 4'b0010) begin
         errors++;
         $display("FAIL mid_pre: outstanding=%0d start=%b expected 3 0010", outstanding, core_start);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (core_start !== '0 || core_x !== '0 || core_y !== '0 || bus.win_ready !== 1'b0 ||
          bus.res_valid !== 1'b0 || outstanding !== '0 || scale_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: start=%b x=%0d wr=%b rv=%b out=%0d sd=%b expected all 0",
                  core_start, core_x, bus.win_ready, bus.res_valid, outstanding, scale_done);
      end
      tick();
      reset = 1'b0;
      tick();
      open_scale();
      bus.win_valid = 1'b1;
      bus.win_x     = 16'd9;
      bus.win_y     = 16'd3;
      tick();
      bus.win_valid = 1'b0;
      tick();
      checks++;
      if (core_start !== 4'b0001 || core_x !== 16'd9) begin
         errors++;
         $display("FAIL mid_restart: start=%b x=%0d expected 0001 9", core_start, core_x);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_simultaneous_done();
      test_backpressure();
      test_spurious_done();
      test_random_pass(6);
      test_random_pass(40);
      test_reset_mid_pass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
